regfile_scoreboard: RTL and testbench
=====================================

// Module: regfile_scoreboard
// PURPOSE
//  Parametrised successor to the pipeline's 32x32 register file: DEPTH x DATA_W storage, 2 async read
//  ports, 1 sync write port, optional write-to-read bypass and a per-register busy scoreboard.
//  Decode reserves a destination at issue; writeback clears it. The hazard unit stalls on rd_busyN.
// PARAMETERS
//  DATA_W    32  register width in bits
//  ADDR_W     5  address width; DEPTH = 2**ADDR_W registers
//  ZERO_REG   1  1: register 0 always reads 0; writes and reservations to it are ignored
//  BYPASS     1  1: same-cycle write data/clear forwarded to read ports; 0: visible next cycle
// PORTS
//  clk        in   1        rising-edge clock
//  reset      in   1        asynchronous, active-high; clears all registers and busy bits
//  rd_addr1   in   ADDR_W   read port 1 address
//  rd_data1   out  DATA_W   read port 1 data (combinational)
//  rd_busy1   out  1        rd_addr1 has a pending reservation (combinational)
//  rd_addr2   in   ADDR_W   read port 2 address
//  rd_data2   out  DATA_W   read port 2 data (combinational)
//  rd_busy2   out  1        rd_addr2 has a pending reservation (combinational)
//  wr_en      in   1        write strobe (writeback stage)
//  wr_addr    in   ADDR_W   write address
//  wr_data    in   DATA_W   write data
//  rsv_en     in   1        reserve strobe (issue stage): set busy[rsv_addr]
//  rsv_addr   in   ADDR_W   register to reserve
//  flush      in   1        clear every busy bit at next edge; register contents unaffected
//  busy_cnt   out  ADDR_W+1 registered count of set busy bits
// BEHAVIOUR
//  - Reset (async, any time incl. mid-write): all regs = 0, busy = 0, busy_cnt = 0. rd_dataN = 0 and
//    rd_busyN = 0 while reset is high. A write or reserve coincident with reset is dropped.
//  - Write: at posedge, if wr_en and !(ZERO_REG && wr_addr==0): reg[wr_addr] <= wr_data and
//    busy[wr_addr] <= 0 (unless set by a same-cycle reserve; see below). Latency 1 cycle.
//  - Reserve: at posedge, if rsv_en and !(ZERO_REG && rsv_addr==0): busy[rsv_addr] <= 1.
//  - Same address, wr_en and rsv_en in one cycle: data written AND busy ends 1 (new producer wins).
//  - Reserve on an already-busy register: stays 1; busy_cnt unchanged (no double count).
//  - Write to a non-busy register: legal; data written, busy stays 0.
//  - flush: busy <= all 0 and busy_cnt <= 0; same-cycle reserve is ignored; same-cycle write still
//    updates data.
//  - Read, ZERO_REG && addr==0: data 0, busy 0.
//  - Read, BYPASS=1 and wr_en && wr_addr==rd_addrN (nonzero under ZERO_REG): rd_dataN = wr_data.
//    rd_busyN = 0 unless rsv_en && rsv_addr==rd_addrN in the same cycle.
//  - Read, BYPASS=0, or no match: rd_dataN = reg[rd_addrN], rd_busyN = busy[rd_addrN]
//    (registered state only).
//  - Reservations never forward. rd_busyN reflects a new reserve from the next cycle.
//  - busy_cnt equals popcount(busy) after every edge. Max DEPTH (or DEPTH-1 under ZERO_REG),
//    which cannot overflow.
//  - Both read ports are independent; identical addresses return identical results.
// TESTING
//  1 Reset: write 0xDEADBEEF to r5, assert reset between edges -> rd_data1(r5)=0 immediately,
//    busy_cnt=0.
//  2 Zero reg: wr r0=0x1234, rsv r0 -> rd_data1(r0)=0, rd_busy1=0, busy_cnt=0 (ZERO_REG=1).
//  3 Scoreboard: rsv r7 cycle 0 -> rd_busy2(r7)=1, busy_cnt=1 from cycle 1; wr r7=0xA5A5A5A5
//    cycle 3 -> rd_data2=0xA5A5A5A5, rd_busy2=0 in cycle 3 (BYPASS=1); busy_cnt=0 at cycle 4.
//  4 Conflict: r9 busy; same cycle wr r9=0x11 + rsv r9 -> reg r9=0x11, busy[r9]=1, busy_cnt=1.
//  5 Flush: rsv r1, r2, r3 -> busy_cnt=3; flush + rsv r4 + wr r2=0x22 -> busy_cnt=0,
//    all busy 0, r2=0x22.
//  6 BYPASS=0, DATA_W=16, ADDR_W=3: wr r3=0xBEEF -> same cycle rd r3 = old value; next cycle 0xBEEF.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with two async read ports, one sync write port,
// optional write-to-read bypass and a per-register busy scoreboard with popcount.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [DATA_W-1:0] rd_data1,
  output logic              rd_busy1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              flush,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);
  localparam bit BP    = (BYPASS != 0);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   busy_cnt_q, busy_cnt_d;
  logic              wr_ok, rsv_ok;

  function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] v);
    logic [ADDR_W:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      c = c + {{ADDR_W{1'b0}}, v[i]};
    end
    return c;
  endfunction

  assign wr_ok  = wr_en  && !(ZR && (wr_addr  == '0));
  assign rsv_ok = rsv_en && !(ZR && (rsv_addr == '0));

  // Writeback clears first, then a same-cycle reserve re-arms: the newer producer wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok) begin
      busy_d[wr_addr] = 1'b0;
    end
    if (flush) begin
      busy_d = '0;
    end else if (rsv_ok) begin
      busy_d[rsv_addr] = 1'b1;
    end
    busy_cnt_d = popcount(busy_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
      if (wr_ok) begin
        regs_q[wr_addr] <= wr_data;
      end
    end
  end

  assign busy_cnt = busy_cnt_q;

  // Forwarding only covers the write's data and its busy clear; reservations show next cycle.
  always_comb begin
    rd_data1 = regs_q[rd_addr1];
    rd_busy1 = busy_q[rd_addr1];
    if (reset || (ZR && (rd_addr1 == '0))) begin
      rd_data1 = '0;
      rd_busy1 = 1'b0;
    end else if (BP && wr_ok && (wr_addr == rd_addr1)) begin
      rd_data1 = wr_data;
      if (!(rsv_en && (rsv_addr == rd_addr1))) begin
        rd_busy1 = 1'b0;
      end
    end
  end

  always_comb begin
    rd_data2 = regs_q[rd_addr2];
    rd_busy2 = busy_q[rd_addr2];
    if (reset || (ZR && (rd_addr2 == '0))) begin
      rd_data2 = '0;
      rd_busy2 = 1'b0;
    end else if (BP && wr_ok && (wr_addr == rd_addr2)) begin
      rd_data2 = wr_data;
      if (!(rsv_en && (rsv_addr == rd_addr2))) begin
        rd_busy2 = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench: a 32x32 bypassing instance and an 8x16 non-bypassing instance
// share one stimulus stream and are each checked against an array-based reference model.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  rd_addr1 = '0, rd_addr2 = '0, wr_addr = '0, rsv_addr = '0;
  logic [31:0] wr_data = '0;
  logic        wr_en = 1'b0, rsv_en = 1'b0, flush = 1'b0;

  logic [31:0] a_rd_data1, a_rd_data2;
  logic        a_rd_busy1, a_rd_busy2;
  logic [5:0]  a_busy_cnt;
  logic [15:0] b_rd_data1, b_rd_data2;
  logic        b_rd_busy1, b_rd_busy2;
  logic [3:0]  b_busy_cnt;

  always #5 clk = ~clk;

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .reset(reset),
    .rd_addr1(rd_addr1), .rd_data1(a_rd_data1), .rd_busy1(a_rd_busy1),
    .rd_addr2(rd_addr2), .rd_data2(a_rd_data2), .rd_busy2(a_rd_busy2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush), .busy_cnt(a_busy_cnt)
  );

  regfile_scoreboard #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(0)) dut_b (
    .clk(clk), .reset(reset),
    .rd_addr1(rd_addr1[2:0]), .rd_data1(b_rd_data1), .rd_busy1(b_rd_busy1),
    .rd_addr2(rd_addr2[2:0]), .rd_data2(b_rd_data2), .rd_busy2(b_rd_busy2),
    .wr_en(wr_en), .wr_addr(wr_addr[2:0]), .wr_data(wr_data[15:0]),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr[2:0]), .flush(flush), .busy_cnt(b_busy_cnt)
  );

  typedef struct {
    int              tid;
    logic [1:0][31:0] d1, d2;
    logic [1:0]       b1, b2;
    logic [1:0][31:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: m=0 is the 32-entry bypassing file, m=1 the 8-entry 16-bit file.
  logic [31:0] mreg  [2][32];
  bit          mbusy [2][32];

  function automatic logic [4:0] am(input int m, input logic [4:0] a);
    return (m == 0) ? a : (a & 5'd7);
  endfunction

  function automatic logic [31:0] dm(input int m, input logic [31:0] d);
    return (m == 0) ? d : (d & 32'h0000_FFFF);
  endfunction

  function automatic int depth(input int m);
    return (m == 0) ? 32 : 8;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 32; i++) begin
        mreg[m][i]  = '0;
        mbusy[m][i] = 1'b0;
      end
  endtask

  function automatic logic [31:0] model_cnt(input int m);
    int n = 0;
    for (int i = 0; i < depth(m); i++) n += int'(mbusy[m][i]);
    return n;
  endfunction

  task automatic exp_read(input int m, input logic [4:0] ra, output logic [31:0] d, output logic b);
    logic [4:0] a;
    a = am(m, ra);
    d = mreg[m][a];
    b = mbusy[m][a];
    if (reset || a == 0) begin
      d = '0;
      b = 1'b0;
    end else if (m == 0 && wr_en && am(m, wr_addr) == a) begin
      d = dm(m, wr_data);
      if (!(rsv_en && am(m, rsv_addr) == a)) b = 1'b0;
    end
  endtask

  task automatic model_edge();
    logic [4:0] a;
    for (int m = 0; m < 2; m++) begin
      if (wr_en) begin
        a = am(m, wr_addr);
        if (a != 0) begin
          mreg[m][a]  = dm(m, wr_data);
          mbusy[m][a] = 1'b0;
        end
      end
      if (flush) begin
        for (int i = 0; i < 32; i++) mbusy[m][i] = 1'b0;
      end else if (rsv_en) begin
        a = am(m, rsv_addr);
        if (a != 0) mbusy[m][a] = 1'b1;
      end
    end
  endtask

  // Called one time unit after a rising edge; applies inputs for the coming edge.
  task automatic cycle(input int tid, input bit r, input bit we, input logic [4:0] wa,
                       input logic [31:0] wd, input bit re, input logic [4:0] ra,
                       input bit fl, input logic [4:0] a1, input logic [4:0] a2);
    exp_t e;
    logic [31:0] d;
    logic b;
    reset = r; wr_en = we; wr_addr = wa; wr_data = wd;
    rsv_en = re; rsv_addr = ra; flush = fl; rd_addr1 = a1; rd_addr2 = a2;
    if (r) model_reset();
    e.tid = tid;
    for (int m = 0; m < 2; m++) begin
      exp_read(m, a1, d, b); e.d1[m] = d; e.b1[m] = b;
      exp_read(m, a2, d, b); e.d2[m] = d; e.b2[m] = b;
      e.cnt[m] = model_cnt(m);
    end
    q.push_back(e);
    if (!r) model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int tid, input logic [4:0] a1, input logic [4:0] a2);
    cycle(tid, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, a1, a2);
  endtask

  task automatic chk(input int tid, input string nm, input int m, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL t%0d %s dut%0d got %h exp %h", tid, nm, m, got, exp);
    end
  endtask

  // Monitor: outputs are combinational/registered and present every cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk(e.tid, "rd_data1", 0, a_rd_data1, e.d1[0]);
      chk(e.tid, "rd_busy1", 0, {31'd0, a_rd_busy1}, {31'd0, e.b1[0]});
      chk(e.tid, "rd_data2", 0, a_rd_data2, e.d2[0]);
      chk(e.tid, "rd_busy2", 0, {31'd0, a_rd_busy2}, {31'd0, e.b2[0]});
      chk(e.tid, "busy_cnt", 0, {26'd0, a_busy_cnt}, e.cnt[0]);
      chk(e.tid, "rd_data1", 1, {16'd0, b_rd_data1}, e.d1[1]);
      chk(e.tid, "rd_busy1", 1, {31'd0, b_rd_busy1}, {31'd0, e.b1[1]});
      chk(e.tid, "rd_data2", 1, {16'd0, b_rd_data2}, e.d2[1]);
      chk(e.tid, "rd_busy2", 1, {31'd0, b_rd_busy2}, {31'd0, e.b2[1]});
      chk(e.tid, "busy_cnt", 1, {28'd0, b_busy_cnt}, e.cnt[1]);
    end
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    model_reset();
    @(posedge clk); #1;
    cycle(0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd7);
    idle(0, 5'd5, 5'd7);
    // 1: reset mid-cycle after a write
    cycle(1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd5, 5'd5);
    idle(1, 5'd5, 5'd5);
    cycle(1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd5);
    idle(1, 5'd5, 5'd5);
    // 2: register zero
    cycle(2, 1'b0, 1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0);
    idle(2, 5'd0, 5'd0);
    // 3: reserve then writeback with bypass
    cycle(3, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 5'd7, 5'd7);
    idle(3, 5'd7, 5'd7);
    idle(3, 5'd7, 5'd7);
    cycle(3, 1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 1'b0, 5'd7, 5'd7);
    idle(3, 5'd7, 5'd7);
    // 4: write and reserve collide on a busy register
    cycle(4, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 5'd9, 5'd9);
    cycle(4, 1'b0, 1'b1, 5'd9, 32'h11, 1'b1, 5'd9, 1'b0, 5'd9, 5'd9);
    idle(4, 5'd9, 5'd9);
    // 5: flush beats a same-cycle reserve, write still lands
    cycle(5, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd1, 5'd2);
    cycle(5, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 1'b0, 5'd1, 5'd2);
    cycle(5, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 1'b0, 5'd1, 5'd2);
    cycle(5, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b0, 5'd3, 5'd2);
    cycle(5, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 1'b0, 5'd3, 5'd2);
    cycle(5, 1'b0, 1'b1, 5'd2, 32'h22, 1'b1, 5'd4, 1'b1, 5'd4, 5'd2);
    idle(5, 5'd4, 5'd2);
    idle(5, 5'd1, 5'd3);
    // 6: write r3 seen by both instances (bypass only on the 32-bit one)
    cycle(6, 1'b0, 1'b1, 5'd3, 32'h0000BEEF, 1'b0, 5'd0, 1'b0, 5'd3, 5'd3);
    idle(6, 5'd3, 5'd3);
    // 7: randomized traffic with narrow address range for collisions
    for (int n = 0; n < 500; n++) begin
      cycle(7, ($urandom_range(0, 99) == 0),
            ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 15)), $urandom(),
            ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 15)),
            ($urandom_range(0, 19) == 0),
            5'($urandom_range(0, 15)), 5'($urandom_range(0, 31)));
    end
    idle(8, 5'd0, 5'd0);
    @(negedge clk); #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain queue got %0d exp 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
